gost89_cfb_sched: RTL and testbench

- Round-robin scheduler that time-shares one gost89_cfb core between NCH independent CFB streams.
- Each channel has its own key, IV/feedback (chain) register and per-block mode.
- Before each block, the core's gamma is reloaded from that channel's chain register, so streams interleave freely block by block.
- Sits between stream clients (DMA or bus-side queues) and the single CFB/ECB datapath.

---
 rtl/gost89_pkg.sv | 43 ++++
 rtl/gost89_cfb_sched_if.sv | 35 +++
 rtl/gost89_cfb.sv | 71 +++++++
 rtl/gost89_cfb_sched.sv | 129 ++++++++++++
 tb/tb_gost89_cfb_sched.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gost89_pkg.sv
// Shared widths, scheduler state encoding and the round-robin pick helper
// for the GOST 28147-89 CFB channel scheduler.
`default_nettype none

package gost89_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 256;
  localparam int SBOX_W  = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    LOAD  = 3'd2,
    WAIT1 = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // First requesting channel strictly after ptr, wrapping modulo nch
  // (ptr itself is considered last).
  function automatic logic [2:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input logic [3:0] nch);
    logic [2:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= nch) idx = idx - nch;
      if (!found && (4'(k) <= nch) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gost89_cfb_sched_if.sv
// Client-side bus of the CFB scheduler: shared S-box, per-channel keys,
// IV writes, level requests and the response stream.
`default_nettype none

interface gost89_cfb_sched_if #(parameter int NCH = 2);
  import gost89_pkg::*;

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [SBOX_W-1:0]      sbox;
  logic [KEY_W*NCH-1:0]   key;
  logic [NCH-1:0]         iv_wr;
  logic [BLOCK_W-1:0]     iv_data;
  logic [NCH-1:0]         req;
  logic [NCH-1:0]         mode;
  logic [BLOCK_W*NCH-1:0] data;
  logic [NCH-1:0]         ack;
  logic                   rsp_valid;
  logic [CW-1:0]          rsp_ch;
  logic [BLOCK_W-1:0]     rsp_data;
  logic                   busy;

  modport master (
    output sbox, key, iv_wr, iv_data, req, mode, data,
    input  ack, rsp_valid, rsp_ch, rsp_data, busy
  );

  modport slave (
    input  sbox, key, iv_wr, iv_data, req, mode, data,
    output ack, rsp_valid, rsp_ch, rsp_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/gost89_cfb.sv
// Single GOST 28147-89 CFB core: one Feistel round per clock, 32 rounds.
// reset=1 preloads the gamma from in; load_data starts a block on in.
`default_nettype none

module gost89_cfb
  import gost89_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               load_data,
  input  logic [SBOX_W-1:0]  sbox,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] in,
  output logic [BLOCK_W-1:0] out,
  output logic               busy
);

  logic [BLOCK_W-1:0] gamma;
  logic [BLOCK_W-1:0] data_r;
  logic               mode_r;
  logic [31:0]        n1, n2;
  logic [4:0]         rnd;

  logic [2:0]  kidx;
  logic [31:0] kw, t, s, f, nn1, nn2;
  logic [BLOCK_W-1:0] enc;

  // Rounds 0..23 walk K0..K7 forward three times, rounds 24..31 walk back.
  always_comb begin
    kidx = (rnd < 5'd24) ? rnd[2:0] : ~rnd[2:0];
    kw   = key[32*kidx +: 32];
    t    = n1 + kw;
    s    = '0;
    for (int j = 0; j < 8; j++) begin
      s[4*j +: 4] = sbox[64*j + 4*int'(t[4*j +: 4]) +: 4];
    end
    f    = {s[20:0], s[31:21]};
    nn1  = n2 ^ f;
    nn2  = n1;
    enc  = {nn1, nn2};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gamma <= in;
      busy  <= 1'b0;
      rnd   <= '0;
    end else if (load_data) begin
      data_r <= in;
      mode_r <= mode;
      n1     <= gamma[31:0];
      n2     <= gamma[63:32];
      rnd    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      n1  <= nn1;
      n2  <= nn2;
      rnd <= rnd + 5'd1;
      if (rnd == 5'd31) begin
        busy  <= 1'b0;
        out   <= data_r ^ enc;
        // Feedback is always the ciphertext side of the exchange.
        gamma <= mode_r ? data_r : (data_r ^ enc);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gost89_cfb_sched.sv
// Round-robin scheduler sharing one gost89_cfb core between NCH CFB streams,
// each with its own key, chain register and per-block direction.
`default_nettype none

module gost89_cfb_sched
  import gost89_pkg::*;
#(
  parameter int NCH = 2
)
(
  input logic               clk,
  input logic               reset_n,
  gost89_cfb_sched_if.slave bus
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t             state;
  logic [CW-1:0]      g, rr, pick;
  logic [2:0]         pick_full;
  logic [KEY_W-1:0]   key_q;
  logic [BLOCK_W-1:0] data_q;
  logic               mode_q;
  logic [BLOCK_W-1:0] chain  [NCH];
  logic [BLOCK_W-1:0] data_a [NCH];
  logic [KEY_W-1:0]   key_a  [NCH];

  logic               core_reset, core_load, core_mode, core_busy;
  logic [BLOCK_W-1:0] core_in, core_out;

  for (genvar i = 0; i < NCH; i++) begin : g_slice
    assign data_a[i] = bus.data[BLOCK_W*i +: BLOCK_W];
    assign key_a[i]  = bus.key[KEY_W*i +: KEY_W];
  end

  assign pick_full = rr_next(8'(bus.req), 3'(rr), 4'(NCH));
  assign pick      = CW'(pick_full);

  // SEED presents the chain while the core is still in reset, which is how
  // the gamma of the granted channel gets preloaded.
  always_comb begin
    core_reset = (state == IDLE) || (state == SEED);
    core_load  = (state == LOAD);
    core_in    = (state == LOAD) ? data_a[g] : chain[g];
    core_mode  = bus.mode[g];
  end

  gost89_cfb u_core (
    .clk       (clk),
    .reset     (core_reset),
    .mode      (core_mode),
    .load_data (core_load),
    .sbox      (bus.sbox),
    .key       (key_q),
    .in        (core_in),
    .out       (core_out),
    .busy      (core_busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      g             <= '0;
      rr            <= '0;
      key_q         <= '0;
      data_q        <= '0;
      mode_q        <= 1'b0;
      bus.ack       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_ch    <= '0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.ack       <= '0;
      bus.rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            g        <= pick;
            key_q    <= key_a[pick];
            bus.busy <= 1'b1;
            state    <= SEED;
          end
        end
        SEED: begin
          bus.ack <= NCH'(1) << g;
          state   <= LOAD;
        end
        LOAD: begin
          data_q <= data_a[g];
          mode_q <= bus.mode[g];
          state  <= WAIT1;
        end
        WAIT1: state <= RUN;
        RUN: begin
          if (!core_busy) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_ch    <= g;
            bus.rsp_data  <= core_out;
            state         <= DONE;
          end
        end
        DONE: begin
          rr       <= g;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A host IV write in DONE overrides the feedback for that channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) chain[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.iv_wr[i])
          chain[i] <= bus.iv_data;
        else if ((state == DONE) && (g == CW'(i)))
          chain[i] <= mode_q ? data_q : core_out;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gost89_cfb_sched.sv
// Directed self-checking bench for gost89_cfb_sched with two channels.
`default_nettype none

module tb_gost89_cfb_sched;
  import gost89_pkg::*;

  localparam int NCH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gost89_cfb_sched_if #(.NCH(NCH)) bus();
  gost89_cfb_sched #(.NCH(NCH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [511:0] sb;
  logic [255:0] k0, k1;
  logic [63:0]  iv_a = 64'h0123456789ABCDEF;
  logic [63:0]  gm [2];
  logic [63:0]  last_rsp;

  // Reference block encryption: 31 swapping rounds, final round without swap.
  function automatic logic [63:0] gost_e(input logic [511:0] sbx, input logic [255:0] k,
                                         input logic [63:0] b);
    logic [31:0] n1, n2, t, s, f, tmp;
    int ki;
    n1 = b[31:0];
    n2 = b[63:32];
    for (int r = 0; r < 32; r++) begin
      ki = (r < 24) ? (r % 8) : (7 - (r % 8));
      t  = n1 + k[32*ki +: 32];
      s  = '0;
      for (int j = 0; j < 8; j++) s[4*j +: 4] = sbx[64*j + 4*int'(t[4*j +: 4]) +: 4];
      f  = (s << 11) | (s >> 21);
      if (r < 31) begin
        tmp = n1; n1 = n2 ^ f; n2 = tmp;
      end else begin
        n2 = n2 ^ f;
      end
    end
    return {n2, n1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_iv(input logic [NCH-1:0] mask, input logic [63:0] v);
    bus.iv_wr   = mask;
    bus.iv_data = v;
    tick();
    bus.iv_wr   = '0;
  endtask

  task automatic do_block(input int ch, input logic m, input logic [63:0] d,
                          input logic iv_at_done, input logic [63:0] iv_new,
                          output int ack_lat, output int rsp_lat,
                          output logic [63:0] rd, output int rc);
    ack_lat = -1; rsp_lat = -1; rd = '0; rc = -1;
    bus.data[64*ch +: 64] = d;
    bus.mode[ch] = m;
    bus.req[ch]  = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.ack[ch]) begin ack_lat = n; break; end
    end
    bus.req[ch] = 1'b0;
    if (ack_lat > 0) begin
      for (int n = 1; n <= 100; n++) begin
        tick();
        if (bus.rsp_valid) begin
          rsp_lat = n;
          rd = bus.rsp_data;
          rc = int'(bus.rsp_ch);
          if (iv_at_done) begin
            bus.iv_data = iv_new;
            bus.iv_wr   = NCH'(1) << ch;
          end
          break;
        end
      end
    end
    tick();
    bus.iv_wr = '0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", bus.ack); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 64'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
    checks++; if (bus.rsp_ch !== 1'b0) begin errors++; $display("FAIL reset_rsp_ch got %b exp 0", bus.rsp_ch); end
    checks++; if (dut.chain[1] !== 64'h0) begin errors++; $display("FAIL reset_chain1 got %h exp 0", dut.chain[1]); end
    checks++; if (dut.core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got %b exp 1", dut.core_reset); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_encrypt();
    int al, rl, rc;
    logic [63:0] rd, e;
    write_iv(2'b01, iv_a);
    do_block(0, 1'b0, 64'h0, 1'b0, 64'h0, al, rl, rd, rc);
    e = gost_e(sb, k0, iv_a);
    checks++; if (al !== 2) begin errors++; $display("FAIL single_ack_latency got %0d exp 2", al); end
    checks++; if (rl !== 34) begin errors++; $display("FAIL single_rsp_latency got %0d exp 34", rl); end
    checks++; if (rd !== e) begin errors++; $display("FAIL single_rsp_data got %h exp %h", rd, e); end
    checks++; if (rc !== 0) begin errors++; $display("FAIL single_rsp_ch got %0d exp 0", rc); end
    checks++; if (dut.chain[0] !== e) begin errors++; $display("FAIL single_chain got %h exp %h", dut.chain[0], e); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", bus.busy); end
    gm[0] = e;
  endtask

  task automatic test_round_trip();
    int al, rl, rc;
    logic [63:0] rd, e;
    logic [63:0] p [3];
    logic [63:0] c [3];
    p[0] = 64'hDEADBEEF00000001;
    p[1] = 64'h1122334455667788;
    p[2] = 64'hFFFFFFFFFFFFFFFF;
    write_iv(2'b01, iv_a);
    gm[0] = iv_a;
    for (int i = 0; i < 3; i++) begin
      do_block(0, 1'b0, p[i], 1'b0, 64'h0, al, rl, rd, rc);
      e = p[i] ^ gost_e(sb, k0, gm[0]);
      gm[0] = e;
      c[i] = rd;
      checks++; if (rd !== e) begin errors++; $display("FAIL rt_enc%0d got %h exp %h", i, rd, e); end
    end
    bus.key[511:256] = k0;
    write_iv(2'b10, iv_a);
    for (int i = 0; i < 3; i++) begin
      do_block(1, 1'b1, c[i], 1'b0, 64'h0, al, rl, rd, rc);
      checks++; if (rd !== p[i]) begin errors++; $display("FAIL rt_dec%0d got %h exp %h", i, rd, p[i]); end
      checks++; if (rc !== 1) begin errors++; $display("FAIL rt_ch%0d got %0d exp 1", i, rc); end
    end
    bus.key[511:256] = k1;
  endtask

  task automatic test_interleave();
    int sent [2];
    int rcnt [2];
    logic upd [2];
    int nrsp, c;
    logic [63:0] e, kk;
    logic [255:0] kc;
    sent[0] = 0; sent[1] = 0; rcnt[0] = 0; rcnt[1] = 0;
    upd[0] = 1'b0; upd[1] = 1'b0;
    nrsp = 0;
    write_iv(2'b11, 64'hA5A5A5A5C3C3C3C3);
    gm[0] = 64'hA5A5A5A5C3C3C3C3;
    gm[1] = 64'hA5A5A5A5C3C3C3C3;
    bus.mode = 2'b00;
    bus.data[63:0]   = {32'd0, 32'd0} ^ 64'h0F0F0F0F0F0F0F0F;
    bus.data[127:64] = {32'd1, 32'd0} ^ 64'h0F0F0F0F0F0F0F0F;
    bus.req = 2'b11;
    for (int n = 0; n < 2000 && nrsp < 8; n++) begin
      tick();
      for (int ch = 0; ch < 2; ch++) begin
        if (upd[ch]) begin
          upd[ch] = 1'b0;
          sent[ch]++;
          if (sent[ch] < 4) bus.data[64*ch +: 64] = {32'(ch), 32'(sent[ch])} ^ 64'h0F0F0F0F0F0F0F0F;
          else bus.req[ch] = 1'b0;
        end
        if (bus.ack[ch]) upd[ch] = 1'b1;
      end
      if (bus.rsp_valid) begin
        c  = int'(bus.rsp_ch);
        checks++; if (c !== (nrsp % 2)) begin errors++; $display("FAIL il_order%0d got %0d exp %0d", nrsp, c, nrsp % 2); end
        kc = (c == 0) ? k0 : k1;
        kk = {32'(c), 32'(rcnt[c])} ^ 64'h0F0F0F0F0F0F0F0F;
        e  = kk ^ gost_e(sb, kc, gm[c]);
        gm[c] = e;
        rcnt[c]++;
        checks++; if (bus.rsp_data !== e) begin errors++; $display("FAIL il_data%0d got %h exp %h", nrsp, bus.rsp_data, e); end
        nrsp++;
      end
    end
    bus.req = 2'b00;
    checks++; if (nrsp !== 8) begin errors++; $display("FAIL il_count got %0d exp 8", nrsp); end
    tick(); tick();
  endtask

  task automatic test_iv_at_done();
    int al, rl, rc;
    logic [63:0] rd, e;
    logic [63:0] ivn = 64'h0BADF00DCAFEBABE;
    do_block(0, 1'b0, 64'h5555AAAA5555AAAA, 1'b1, ivn, al, rl, rd, rc);
    e = 64'h5555AAAA5555AAAA ^ gost_e(sb, k0, gm[0]);
    checks++; if (rd !== e) begin errors++; $display("FAIL ivd_rsp got %h exp %h", rd, e); end
    checks++; if (dut.chain[0] !== ivn) begin errors++; $display("FAIL ivd_chain got %h exp %h", dut.chain[0], ivn); end
    do_block(0, 1'b0, 64'h0000FFFF0000FFFF, 1'b0, 64'h0, al, rl, rd, rc);
    e = 64'h0000FFFF0000FFFF ^ gost_e(sb, k0, ivn);
    checks++; if (rd !== e) begin errors++; $display("FAIL ivd_next got %h exp %h", rd, e); end
    gm[0] = e;
  endtask

  task automatic test_reset_mid();
    int al, rl, rc, seen, acked;
    logic [63:0] rd, e;
    acked = 0;
    bus.data[127:64] = 64'h123456789ABCDEF0;
    bus.mode[1] = 1'b0;
    bus.req[1]  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus.ack[1]) begin acked = 1; break; end
    end
    bus.req[1] = 1'b0;
    checks++; if (acked !== 1) begin errors++; $display("FAIL rm_ack got %0d exp 1", acked); end
    for (int n = 0; n < 10; n++) tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %b exp 1", bus.busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy_async got %b exp 0", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.ack !== 2'b00) begin errors++; $display("FAIL rm_outputs got %b/%b exp 0/00", bus.rsp_valid, bus.ack); end
    checks++; if (dut.chain[0] !== 64'h0) begin errors++; $display("FAIL rm_chain0 got %h exp 0", dut.chain[0]); end
    tick(); tick(); tick();
    reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_rsp got %0d exp 0", seen); end
    do_block(0, 1'b0, 64'hFEEDFACE00C0FFEE, 1'b0, 64'h0, al, rl, rd, rc);
    e = 64'hFEEDFACE00C0FFEE ^ gost_e(sb, k0, 64'h0);
    checks++; if (rd !== e) begin errors++; $display("FAIL rm_fresh got %h exp %h", rd, e); end
    checks++; if (al !== 2) begin errors++; $display("FAIL rm_fresh_ack got %0d exp 2", al); end
    last_rsp = e;
  endtask

  task automatic test_idle();
    int viol;
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (bus.busy || (bus.ack != 2'b00) || bus.rsp_valid || !dut.core_reset) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL idle_activity got %0d exp 0", viol); end
    checks++; if (bus.rsp_data !== last_rsp) begin errors++; $display("FAIL idle_rsp_hold got %h exp %h", bus.rsp_data, last_rsp); end
    checks++; if (bus.rsp_ch !== 1'b0) begin errors++; $display("FAIL idle_ch_hold got %b exp 0", bus.rsp_ch); end
  endtask

  initial begin
    for (int j = 0; j < 8; j++)
      for (int v = 0; v < 16; v++)
        sb[64*j + 4*v +: 4] = 4'((v * 7 + j * 3 + 5) % 16);
    k0 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0};
    k1 = {64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89};
    bus.sbox    = sb;
    bus.key     = {k1, k0};
    bus.iv_wr   = '0;
    bus.iv_data = '0;
    bus.req     = '0;
    bus.mode    = '0;
    bus.data    = '0;
    last_rsp    = '0;

    test_reset();
    test_single_encrypt();
    test_round_trip();
    test_interleave();
    test_iv_at_done();
    test_reset_mid();
    test_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
